dilate_sequencer: RTL and testbench

- Controls the 32x32 binary-image dilation datapath between the drawing canvas and the DNN classifier.
- On `start`, captures the canvas image and runs it through the external combinational dilation kernel a configurable number of times, one pass per clock.
- Presents the result to the classifier through a valid/ready handshake, in both display order and classifier (bit-reversed) order.
- Owns the image register and the pass counter; the kernel itself stays outside this block.

---
 rtl/dnn_pkg.sv | 24 ++
 rtl/dilate_sequencer.sv | 108 ++++++++++
 tb/tb_dilate_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - shared image geometry, sequencer states and bit-reverse helper
package dnn_pkg;

  localparam int IMG_W    = 32;
  localparam int IMG_H    = 32;
  localparam int IMG_BITS = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DILATE = 2'd2,
    VALID  = 2'd3
  } seq_state_e;

  // Classifier order is display order with the bit index mirrored.
  function automatic logic [IMG_BITS-1:0] bit_reverse(input logic [IMG_BITS-1:0] x);
    logic [IMG_BITS-1:0] r;
    for (int i = 0; i < IMG_BITS; i++) begin
      r[IMG_BITS-1-i] = x[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/dilate_sequencer.sv
// rtl/dilate_sequencer.sv - capture, multi-pass dilation sequencing and classifier handoff
module dilate_sequencer
  import dnn_pkg::*;
#(
  parameter int PASS_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [PASS_W-1:0]   passes_cfg,
  input  logic [IMG_BITS-1:0] in_image,
  output logic [IMG_BITS-1:0] dil_in,
  input  logic [IMG_BITS-1:0] dil_out,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IMG_BITS-1:0] img_show,
  output logic [IMG_BITS-1:0] img_dnn,
  output logic                blank,
  output logic [CNT_W-1:0]    frame_cnt
);

  seq_state_e          state_q, state_d;
  logic [IMG_BITS-1:0] img_q, img_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic                blank_q, blank_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;

  // Next-state logic: capture on start, one kernel pass per DILATE cycle, abort wins over everything.
  always_comb begin
    state_d     = state_q;
    img_d       = img_q;
    pass_d      = pass_q;
    blank_d     = blank_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          img_d   = in_image;
          pass_d  = passes_cfg;
          blank_d = (in_image == '0);
          state_d = LOAD;
        end
      end
      LOAD: begin
        // A blank image cannot grow, so skip the kernel entirely.
        if ((pass_q == '0) || blank_q) begin
          state_d = VALID;
        end else begin
          state_d = DILATE;
        end
      end
      DILATE: begin
        img_d  = dil_out;
        pass_d = pass_q - PASS_W'(1);
        if (pass_q == PASS_W'(1)) begin
          state_d = VALID;
        end
      end
      VALID: begin
        if (out_ready) begin
          state_d     = IDLE;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d     = IDLE;
      img_d       = '0;
      pass_d      = '0;
      blank_d     = 1'b0;
      frame_cnt_d = frame_cnt_q;
    end
  end

  // State, image register, pass counter and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      img_q       <= '0;
      pass_q      <= '0;
      blank_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      img_q       <= img_d;
      pass_q      <= pass_d;
      blank_q     <= blank_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign dil_in    = img_q;
  assign busy      = (state_q == LOAD) || (state_q == DILATE);
  assign out_valid = (state_q == VALID);
  assign img_show  = img_q;
  assign img_dnn   = bit_reverse(img_q);
  assign blank     = blank_q && (state_q == VALID);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dilate_sequencer.sv
// tb/tb_dilate_sequencer.sv - randomized self-checking bench for dilate_sequencer
module tb_dilate_sequencer;

  localparam int NB = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [2:0]    passes_cfg = '0;
  logic [NB-1:0] in_image = '0;
  logic [NB-1:0] dil_in;
  logic [NB-1:0] dil_out;
  logic          busy;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NB-1:0] img_show;
  logic [NB-1:0] img_dnn;
  logic          blank;
  logic [7:0]    frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  // Stub kernel: rotate left by one bit.
  assign dil_out = {dil_in[NB-2:0], dil_in[NB-1]};

  dilate_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .passes_cfg (passes_cfg),
    .in_image   (in_image),
    .dil_in     (dil_in),
    .dil_out    (dil_out),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .img_show   (img_show),
    .img_dnn    (img_dnn),
    .blank      (blank),
    .frame_cnt  (frame_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: P kernel passes of a left rotation move pixel i to (i+P) mod NB.
  function automatic logic [NB-1:0] model_result(input logic [NB-1:0] img, input int p);
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      if (img[i]) r[(i + p) % NB] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [NB-1:0] model_dnn(input logic [NB-1:0] img);
    logic [NB-1:0] r;
    for (int i = 0; i < NB; i++) r[NB-1-i] = img[i];
    return r;
  endfunction

  function automatic logic [NB-1:0] rand_img();
    logic [NB-1:0] r;
    int sel;
    r = '0;
    sel = int'($urandom_range(0, 3));
    if (sel == 1) begin
      r[$urandom_range(0, NB-1)] = 1'b1;
    end else if (sel >= 2) begin
      for (int w = 0; w < NB / 32; w++) r[w*32 +: 32] = $urandom;
    end
    return r;
  endfunction

  function automatic int diff_bits(input logic [NB-1:0] a, input logic [NB-1:0] b);
    return $countones(a ^ b);
  endfunction

  // One complete frame: capture, wait for result, hold under backpressure, handshake.
  task automatic run_frame(input logic [NB-1:0] img, input int p, input int hold, input string tag);
    logic [NB-1:0] exp_img;
    int eff_p;
    int lat;
    eff_p   = (img == '0) ? 0 : p;
    exp_img = model_result(img, eff_p);
    @(negedge clk);
    in_image   = img;
    passes_cfg = 3'(p);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    in_image   = rand_img();
    passes_cfg = 3'($urandom_range(0, 7));
    lat = 0;
    while (!out_valid && lat < 20) begin
      out_ready = 1'($urandom_range(0, 1));
      check_eq({tag, "_busy"}, 64'(busy), 64'd1);
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'(eff_p + 1));
    check_eq({tag, "_busy_off"}, 64'(busy), 64'd0);
    check_eq({tag, "_show"}, 64'(diff_bits(img_show, exp_img)), 64'd0);
    check_eq({tag, "_dnn"}, 64'(diff_bits(img_dnn, model_dnn(exp_img))), 64'd0);
    check_eq({tag, "_blank"}, 64'(blank), 64'(img == '0));
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start    = 1'b1;
      in_image = ~img;
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check_eq({tag, "_hold_show"}, 64'(diff_bits(img_show, exp_img)), 64'd0);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    out_ready  = 1'b0;
    start      = 1'b0;
    exp_frames = (exp_frames + 1) % 256;
    check_eq({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_no_restart"}, 64'(busy), 64'd0);
    check_eq({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
  endtask

  initial begin
    logic [NB-1:0] one5;
    logic [NB-1:0] img;
    int lat;
    bit seen_valid;

    one5 = '0;
    one5[5] = 1'b1;

    #12;
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_blank", 64'(blank), 64'd0);
    check_eq("rst_frame", 64'(frame_cnt), 64'd0);
    check_eq("rst_show", 64'($countones(img_show)), 64'd0);
    check_eq("rst_dnn", 64'($countones(img_dnn)), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases: bypass, multi-pass, blank, backpressure.
    run_frame(one5, 0, 0, "bypass");
    check_eq("bypass_dnn_bit", 64'(img_dnn[1018]), 64'd1);
    run_frame(one5, 3, 0, "multi");
    check_eq("multi_bit8", 64'(img_show[8]), 64'd1);
    run_frame('0, 7, 0, "blankimg");
    run_frame(rand_img() | one5, 2, 10, "backpr");

    // Randomized frames.
    for (int k = 0; k < 30; k++) begin
      run_frame(rand_img(), int'($urandom_range(0, 7)), int'($urandom_range(0, 4)), "rand");
    end

    // Abort in the second DILATE cycle.
    @(negedge clk);
    in_image   = one5;
    passes_cfg = 3'd7;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_show", 64'($countones(img_show)), 64'd0);
    seen_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      out_ready = 1'b1;
      if (out_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check_eq("abort_no_valid", 64'(seen_valid), 64'd0);
    check_eq("abort_frame", 64'(frame_cnt), 64'(exp_frames));

    // Abort together with start in IDLE captures nothing.
    in_image   = one5;
    passes_cfg = 3'd1;
    start      = 1'b1;
    abort      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_eq("abort_start_busy", 64'(busy), 64'd0);
    check_eq("abort_start_show", 64'($countones(img_show)), 64'd0);

    // Asynchronous reset while dilating.
    in_image   = one5;
    passes_cfg = 3'd7;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_valid", 64'(out_valid), 64'd0);
    check_eq("arst_show", 64'($countones(img_show)), 64'd0);
    check_eq("arst_dnn", 64'($countones(img_dnn)), 64'd0);
    check_eq("arst_frame", 64'(frame_cnt), 64'd0);
    exp_frames = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // 256 handshakes wrap the frame counter back to zero.
    for (int k = 0; k < 256; k++) begin
      img = rand_img();
      run_frame(img, int'($urandom_range(0, 1)), 0, "wrap");
    end
    check_eq("wrap_zero", 64'(frame_cnt), 64'd0);

    // Lingering check that nothing restarts spontaneously.
    lat = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (busy || out_valid) lat++;
    end
    check_eq("idle_quiet", 64'(lat), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
